box_sum_9x9: RTL and testbench



---
 rtl/box_pkg.sv | 22 ++
 rtl/column_adder9.sv | 73 +++++++
 rtl/box_sum_9x9.sv | 122 ++++++++++++
 tb/tb_box_sum_9x9.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// box_pkg: shared constants and the column tag carried alongside each column
// through the 9x9 box-sum pipeline.
//   KW       - kernel width/height (9)
//   PIX_W    - pixel width
//   COLSUM_W - width of one 9-pixel column sum (max 2295)
//   SUM_W    - width of the 81-pixel window sum (max 20655)
//   X_W      - width of the column index; rows up to 256 columns wide
package box_pkg;
    localparam int KW       = 9;
    localparam int PIX_W    = 8;
    localparam int COLSUM_W = 12;
    localparam int SUM_W    = 15;
    localparam int X_W      = 8;

    // Sideband travelling with each column: stage valid, frame-end marker
    // and the column's position within the row.
    typedef struct packed {
        logic           valid;
        logic           done;
        logic [X_W-1:0] x;
    } col_tag_t;
endpackage

// File: rtl/column_adder9.sv
// column_adder9: sums one 9-pixel vertical column with a two-stage adder tree.
//   clk, rst_n : clock and asynchronous reset (active high)
//   pix_i      : 9 pixels, pix_i[0] is the newest row
//   tag_i      : column tag (valid/done/x) entering with the pixels
//   colsum_o   : registered column sum, held while no valid column passes
//   tag_o      : tag delayed by the same 2 cycles as colsum_o
module column_adder9
    import box_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KW-1:0][PIX_W-1:0]      pix_i,
    input  col_tag_t                      tag_i,
    output logic [COLSUM_W-1:0]           colsum_o,
    output col_tag_t                      tag_o
);
    // Stage A: four pair sums plus the odd ninth tap.
    logic [PIX_W:0]   pair_reg [4];
    logic [PIX_W-1:0] last_reg;
    col_tag_t         tag_a_reg;
    col_tag_t         tag_b_reg;
    logic [COLSUM_W-1:0] colsum_reg;
    logic [COLSUM_W-1:0] colsum_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pair
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    pair_reg[gi] <= '0;
                end else if (tag_i.valid) begin
                    pair_reg[gi] <= {1'b0, pix_i[2*gi]} + {1'b0, pix_i[2*gi+1]};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_reg  <= '0;
            tag_a_reg <= '0;
        end else begin
            // The tag advances every cycle so done pulses are never lost,
            // even on cycles without a valid column.
            tag_a_reg <= tag_i;
            if (tag_i.valid) begin
                last_reg <= pix_i[KW-1];
            end
        end
    end

    // Stage B: combine the five partial sums.
    always_comb begin
        colsum_next = COLSUM_W'(pair_reg[0]) + COLSUM_W'(pair_reg[1])
                    + COLSUM_W'(pair_reg[2]) + COLSUM_W'(pair_reg[3])
                    + COLSUM_W'(last_reg);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            colsum_reg <= '0;
            tag_b_reg  <= '0;
        end else begin
            tag_b_reg <= tag_a_reg;
            if (tag_a_reg.valid) begin
                colsum_reg <= colsum_next;
            end
        end
    end

    assign colsum_o = colsum_reg;
    assign tag_o    = tag_b_reg;
endmodule

// File: rtl/box_sum_9x9.sv
// box_sum_9x9: streaming 9x9 box sum over columns from the 9-row line buffer.
//   clk, rst_n        : clock and asynchronous reset (active high despite name)
//   valid_i           : one vertical column is presented this cycle
//   done_i            : end-of-frame pulse; restarts the column count at 0
//   data0_i..data8_i  : column taps, data0_i is the newest row
//   sum_o             : 81-pixel window sum, holds between valid strobes
//   valid_o           : sum_o is a complete window (column x >= 8)
//   done_o            : done_i delayed 3 cycles, aligned with the pipeline
// Latency is 3 cycles from valid_i to valid_o.
module box_sum_9x9
    import box_pkg::*;
#(
    parameter int WIDTH = 10
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             done_i,
    input  logic [PIX_W-1:0] data0_i,
    input  logic [PIX_W-1:0] data1_i,
    input  logic [PIX_W-1:0] data2_i,
    input  logic [PIX_W-1:0] data3_i,
    input  logic [PIX_W-1:0] data4_i,
    input  logic [PIX_W-1:0] data5_i,
    input  logic [PIX_W-1:0] data6_i,
    input  logic [PIX_W-1:0] data7_i,
    input  logic [PIX_W-1:0] data8_i,
    output logic [SUM_W-1:0] sum_o,
    output logic             valid_o,
    output logic             done_o
);
    logic [X_W-1:0]          x_reg;
    logic [KW-1:0][PIX_W-1:0] pix;
    col_tag_t                tag_in;
    col_tag_t                tag_b;
    logic [COLSUM_W-1:0]     colsum;
    logic [COLSUM_W-1:0]     hist_reg [KW];
    logic [SUM_W-1:0]        acc_reg;
    logic [SUM_W-1:0]        acc_next;
    logic                    row_start;
    logic                    valid_o_reg;
    logic                    done_o_reg;

    assign pix = {data8_i, data7_i, data6_i, data5_i, data4_i,
                  data3_i, data2_i, data1_i, data0_i};

    // Column position counter. A done in the same cycle as a valid column
    // lets that column keep its old x; the clear applies to the next one.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            x_reg <= '0;
        end else if (done_i) begin
            x_reg <= '0;
        end else if (valid_i) begin
            x_reg <= (x_reg == X_W'(WIDTH - 1)) ? '0 : x_reg + 1'b1;
        end
    end

    assign tag_in = '{valid: valid_i, done: done_i, x: x_reg};

    column_adder9 u_column_adder9 (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_i    (pix),
        .tag_i    (tag_in),
        .colsum_o (colsum),
        .tag_o    (tag_b)
    );

    // Stage C: running window over the last 9 column sums of this row.
    // At x==0 the history is cleared so the oldest entry subtracted later
    // is zero until real columns of the new row have shifted into it.
    assign row_start = (tag_b.x == '0);

    always_comb begin
        acc_next = acc_reg;
        if (row_start) begin
            acc_next = SUM_W'(colsum);
        end else begin
            acc_next = acc_reg + SUM_W'(colsum) - SUM_W'(hist_reg[KW-1]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KW; gi++) begin : g_hist
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    hist_reg[gi] <= '0;
                end else if (tag_b.valid) begin
                    if (gi == 0) begin
                        hist_reg[gi] <= colsum;
                    end else if (row_start) begin
                        hist_reg[gi] <= '0;
                    end else begin
                        hist_reg[gi] <= hist_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_reg     <= '0;
            valid_o_reg <= 1'b0;
            done_o_reg  <= 1'b0;
        end else begin
            done_o_reg  <= tag_b.done;
            valid_o_reg <= tag_b.valid && (tag_b.x >= X_W'(KW - 1));
            if (tag_b.valid) begin
                acc_reg <= acc_next;
            end
        end
    end

    // The accumulator only changes on valid columns, so it doubles as the
    // held output sum.
    assign sum_o   = acc_reg;
    assign valid_o = valid_o_reg;
    assign done_o  = done_o_reg;
endmodule

// File: tb/tb_box_sum_9x9.sv
module tb_box_sum_9x9;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        done_i;
    logic [7:0]  d [9];
    logic [14:0] sum_o;
    logic        valid_o;
    logic        done_o;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic chk_zero = 1'b0;
    logic chk_end  = 1'b0;

    typedef struct {
        int due;
        int sum;
    } exp_t;
    exp_t sum_q[$];
    int   done_q[$];

    // mode 0: every tap = val; mode 1: every tap = column index;
    // mode 2: tap k = k*val
    typedef struct {
        int mode;
        int val;
        int gap_a;
        int gap_b;
        bit done_last;
        int exp8;
        int exp9;
    } row_t;
    row_t tbl[8];

    box_sum_9x9 #(.WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .done_i(done_i),
        .data0_i(d[0]), .data1_i(d[1]), .data2_i(d[2]), .data3_i(d[3]),
        .data4_i(d[4]), .data5_i(d[5]), .data6_i(d[6]), .data7_i(d[7]),
        .data8_i(d[8]),
        .sum_o(sum_o), .valid_o(valid_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and scoreboard: all comparisons live here.
    always @(negedge clk) begin
        if (chk_zero) begin
            tests++;
            if (sum_o != 0) begin fails++; $display("FAIL reset_sum: got %0d expected 0", sum_o); end
            tests++;
            if (valid_o != 0) begin fails++; $display("FAIL reset_valid: got %0d expected 0", valid_o); end
            tests++;
            if (done_o != 0) begin fails++; $display("FAIL reset_done: got %0d expected 0", done_o); end
        end
        if (!rst_n) begin
            if (valid_o) begin
                tests++;
                if (sum_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: cycle %0d sum %0d, no output expected", cyc, sum_o);
                end else begin
                    exp_t e;
                    e = sum_q.pop_front();
                    if (e.due != cyc || int'(sum_o) != e.sum) begin
                        fails++;
                        $display("FAIL window_sum: got %0d at cycle %0d expected %0d at cycle %0d",
                                 sum_o, cyc, e.sum, e.due);
                    end else begin
                        $display("[TB] cycle %0d sum_o=%0d ok", cyc, sum_o);
                    end
                end
            end else if (sum_q.size() > 0 && sum_q[0].due <= cyc) begin
                exp_t e;
                e = sum_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_valid: got valid_o=0 at cycle %0d expected sum %0d", cyc, e.sum);
            end
            if (done_o) begin
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected 0", cyc);
                end else begin
                    int due;
                    due = done_q.pop_front();
                    if (due != cyc) begin
                        fails++;
                        $display("FAIL done_timing: got cycle %0d expected cycle %0d", cyc, due);
                    end else begin
                        $display("[TB] cycle %0d done_o ok", cyc);
                    end
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                int due;
                due = done_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_done: got done_o=0 expected 1 at cycle %0d", due);
            end
        end
        if (chk_end) begin
            tests++;
            if (sum_q.size() != 0) begin fails++; $display("FAIL drain_sum: got %0d pending expected 0", sum_q.size()); end
            tests++;
            if (done_q.size() != 0) begin fails++; $display("FAIL drain_done: got %0d pending expected 0", done_q.size()); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        valid_i = 1'b0;
        done_i  = 1'b0;
    endtask

    task automatic check_zero();
        chk_zero = 1'b1;
        @(negedge clk);
        #1;
        chk_zero = 1'b0;
    endtask

    task automatic drive_col(input int mode, input int val, input int c,
                             input bit exp_en, input int exp_sum, input bit dn);
        exp_t e;
        step();
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0:       d[k] = 8'(val);
                1:       d[k] = 8'(c);
                default: d[k] = 8'(k * val);
            endcase
        end
        valid_i = 1'b1;
        done_i  = dn;
        if (exp_en) begin
            e.due = cyc + 3;
            e.sum = exp_sum;
            sum_q.push_back(e);
        end
        if (dn) done_q.push_back(cyc + 3);
    endtask

    task automatic drive_row(input row_t r);
        for (int c = 0; c < 10; c++) begin
            drive_col(r.mode, r.val, c, c >= 8, (c == 8) ? r.exp8 : r.exp9,
                      r.done_last && c == 9);
            if (c == r.gap_a || c == r.gap_b) begin
                repeat (3) idle();
            end
        end
    endtask

    initial begin
        tbl[0] = '{0,   1, -1, -1, 1'b0,    81,    81};
        tbl[1] = '{0, 255, -1, -1, 1'b0, 20655, 20655};
        tbl[2] = '{1,   0, -1, -1, 1'b0,   324,   405};
        tbl[3] = '{0,  10, -1, -1, 1'b0,   810,   810};
        tbl[4] = '{0,   0, -1, -1, 1'b0,     0,     0};
        tbl[5] = '{1,   0,  2,  7, 1'b0,   324,   405};
        tbl[6] = '{2,  28, -1, -1, 1'b0,  9072,  9072};
        tbl[7] = '{1,   0, -1, -1, 1'b1,   324,   405};

        rst_n   = 1'b1;
        valid_i = 1'b0;
        done_i  = 1'b0;
        for (int k = 0; k < 9; k++) d[k] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        check_zero();

        // Back-to-back rows from the table.
        for (int i = 0; i < 8; i++) begin
            drive_row(tbl[i]);
        end
        idle();
        repeat (4) idle();

        // done_i in mid-row restarts the next row at x=0.
        for (int c = 0; c < 5; c++) drive_col(0, 3, c, 1'b0, 0, c == 4);
        drive_row('{1, 0, -1, -1, 1'b0, 324, 405});
        idle();
        repeat (4) idle();

        // Reset asserted in mid-row discards the in-flight columns.
        for (int c = 0; c < 5; c++) drive_col(0, 7, c, 1'b0, 0, 1'b0);
        step();
        valid_i = 1'b0;
        rst_n   = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        check_zero();
        drive_row('{1, 0, -1, -1, 1'b0, 324, 405});
        drive_row('{0, 2, -1, -1, 1'b0, 162, 162});
        idle();
        repeat (6) idle();

        chk_end = 1'b1;
        @(negedge clk);
        #1;
        chk_end = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
